// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit. It handles forwarding, load-use stalls,
//            branch flushes, memory-wait freeze with timeout, and the
//            stall/flush performance counters.
// Revision : 1.0
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_MEMWAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR     = 2'd2;

    localparam logic [7:0]  c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    logic [1:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_mem_pend;
    logic        w_freeze;
    logic        w_lw_stall;
    logic        w_stall_fd;
    logic        w_flush_d;
    logic        w_flush_e;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Memory stage has priority over Writeback; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a    = fwd_sel(Rs1E);
        w_fwd_b    = fwd_sel(Rs2E);
        w_lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        w_mem_pend = MemReqM && !MemReadyM;
        w_freeze   = (r_state == c_ST_ERR) || w_mem_pend;
        w_stall_fd = w_freeze || (w_lw_stall && !PCSrcE);
        w_flush_d  = !w_freeze && PCSrcE;
        w_flush_e  = !w_freeze && (PCSrcE || w_lw_stall);
    end

    // The combinational controls are forced low while reset is held.
    assign StallF    = reset & w_stall_fd;
    assign StallD    = reset & w_stall_fd;
    assign StallE    = reset & w_freeze;
    assign StallM    = reset & w_freeze;
    assign FlushD    = reset & w_flush_d;
    assign FlushE    = reset & w_flush_e;
    assign ForwardAE = reset ? w_fwd_a : 2'b00;
    assign ForwardBE = reset ? w_fwd_b : 2'b00;
    assign MemErr    = (r_state == c_ST_ERR);
    assign StallCnt  = r_stall_cnt;
    assign FlushCnt  = r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_pend) begin
                        r_state    <= c_ST_MEMWAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                c_ST_MEMWAIT: begin
                    if (MemReadyM) begin
                        r_state    <= c_ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state    <= c_ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_ERR;
                end
                default: begin
                    r_state    <= c_ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall_fd && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_d && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//==============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCnt, FlushCnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Reset pulse placed between clock edges so it acts purely asynchronously.
    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    // Stall/flush outputs packed as {StallF,StallD,StallE,StallM,FlushD,FlushE}
    function automatic logic [5:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b0;
        // A load-use hazard and a forward match are both present during reset.
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7; RdM = 5; RegWriteM = 1; Rs1E = 5;
        step();
        step();
        chk("rst_ctl",      32'(ctl()),     32'h00);
        chk("rst_fwdA",     32'(ForwardAE), 32'h0);
        chk("rst_memerr",   32'(MemErr),    32'h0);
        chk("rst_stallcnt", 32'(StallCnt),  32'h0);
        chk("rst_flushcnt", 32'(FlushCnt),  32'h0);
        clear_inputs();
        reset = 1'b1;
        step();
        chk("idle_ctl",      32'(ctl()),    32'h00);
        chk("idle_stallcnt", 32'(StallCnt), 32'h0);

        // Forwarding
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
        chk("fwdA_mem", 32'(ForwardAE), 32'h2);
        chk("fwdB_mem", 32'(ForwardBE), 32'h2);
        RegWriteM = 0; #1;
        chk("fwdA_wb",  32'(ForwardAE), 32'h1);
        Rs1E = 0; #1;
        chk("fwdA_x0",  32'(ForwardAE), 32'h0);
        RdM = 0; RdW = 0; Rs2E = 0; RegWriteM = 1; #1;
        chk("fwdB_rd0", 32'(ForwardBE), 32'h0);
        RdW = 9; Rs2E = 9; RdM = 3; #1;
        chk("fwdB_wb_other", 32'(ForwardBE), 32'h1);
        clear_inputs(); #1;

        // Load-use
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7; #1;
        chk("lu_ctl", 32'(ctl()), 32'b110001);
        step();
        chk("lu_stallcnt", 32'(StallCnt), 32'd1);
        chk("lu_flushcnt", 32'(FlushCnt), 32'd0);

        // Branch plus load-use
        PCSrcE = 1; #1;
        chk("br_lu_ctl", 32'(ctl()), 32'b000011);
        step();
        chk("br_flushcnt", 32'(FlushCnt), 32'd1);
        chk("br_stallcnt", 32'(StallCnt), 32'd1);
        PCSrcE = 0; RdE = 0; Rs2D = 0; Rs1D = 0; #1;
        chk("lu_x0_ctl", 32'(ctl()), 32'b000000);
        RdE = 4; Rs1D = 4; #1;
        chk("lu_rs1_ctl", 32'(ctl()), 32'b110001);
        clear_inputs();

        // Memory wait: 3 frozen cycles with a branch pending, then ready
        reset_pulse();
        chk("mw_rst_stallcnt", 32'(StallCnt), 32'd0);
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_ctl_%0d", i), 32'(ctl()), 32'b111100);
            step();
        end
        MemReadyM = 1; #1;
        chk("mw_ready_ctl", 32'(ctl()), 32'b000011);
        step();
        chk("mw_stallcnt", 32'(StallCnt), 32'd3);
        chk("mw_flushcnt", 32'(FlushCnt), 32'd1);
        chk("mw_memerr",   32'(MemErr),   32'd0);
        PCSrcE = 0; #1;
        // Single-cycle access must not stall
        chk("mw_1cyc_ctl", 32'(ctl()), 32'b000000);
        step();
        MemReqM = 0; MemReadyM = 0; #1;
        chk("mw_idle_ctl", 32'(ctl()), 32'b000000);

        // Reset mid-MEMWAIT clears the wait counter
        MemReqM = 1;
        for (int i = 0; i < 10; i++) step();
        reset_pulse();
        for (int i = 0; i < 15; i++) step();
        chk("to_15_memerr", 32'(MemErr), 32'd0);
        step();
        chk("to_16_memerr", 32'(MemErr), 32'd1);
        MemReqM = 0; PCSrcE = 1; ResultSrcE0 = 1; RdE = 2; Rs1D = 2; #1;
        chk("err_ctl", 32'(ctl()), 32'b111100);
        step();
        chk("err_sticky", 32'(MemErr), 32'd1);
        reset = 1'b0; #1;
        chk("err_rst_memerr",   32'(MemErr),   32'd0);
        chk("err_rst_stallcnt", 32'(StallCnt), 32'd0);
        chk("err_rst_flushcnt", 32'(FlushCnt), 32'd0);
        reset = 1'b1;
        clear_inputs(); #1;
        chk("err_post_ctl", 32'(ctl()), 32'b000000);
        step();
        chk("err_post_memerr", 32'(MemErr), 32'd0);

        // Saturation
        reset_pulse();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        for (int i = 0; i < 65534; i++) step();
        chk("sat_fffe", 32'(StallCnt), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(StallCnt), 32'hFFFF);
        step();
        step();
        chk("sat_hold", 32'(StallCnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, the maximum number of memory-wait cycles before an error is flagged (valid range 2..255).
REQ-002 SHALL have ports as follows (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute.
- ResultSrcE0  in  1  Execute instruction is a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  5 each  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1 each  register write enables in Memory and Writeback.
- MemReqM  in  1  Memory-stage instruction accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the respective pipeline register.
- FlushD, FlushE  out  1 each  clear the Decode or Execute pipeline register to a bubble.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- MemErr  out  1  sticky memory-timeout error.
- StallCnt, FlushCnt  out  16 each  performance counters.

Function
REQ-003 SHALL compute ForwardAE = 10 if RegWriteM and RdM != 0 and RdM == Rs1E; else 01 if RegWriteW and RdW != 0 and RdW == Rs1E; else 00. Memory stage takes priority over Writeback.
REQ-004 SHALL compute ForwardBE identically to ForwardAE, using Rs2E in place of Rs1E.
REQ-005 SHALL define lwStall = ResultSrcE0 and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
REQ-006 SHALL define freeze = (state == ERR) or (MemReqM and not MemReadyM), evaluated combinationally in the same cycle.
REQ-007 SHALL drive StallE = StallM = freeze.
REQ-008 SHALL drive StallF = StallD = freeze or (lwStall and not PCSrcE).
REQ-009 SHALL drive FlushD = not freeze and PCSrcE.
REQ-010 SHALL drive FlushE = not freeze and (PCSrcE or lwStall).
REQ-011 SHALL give freeze priority over all other conditions: no flush is issued while frozen, and a pending PCSrcE takes effect on the first unfrozen cycle.
REQ-012 SHALL keep a registered state machine with states RUN, MEMWAIT and ERR, plus an 8-bit wait counter WaitCnt.
REQ-013 State transitions SHALL be:
- RUN -> MEMWAIT when MemReqM and not MemReadyM; WaitCnt is loaded with 1.
- MEMWAIT -> RUN when MemReadyM; WaitCnt is cleared.
- MEMWAIT, not ready, WaitCnt == TIMEOUT-1 -> ERR.
- MEMWAIT, not ready, otherwise: stay in MEMWAIT; WaitCnt increments.
- ERR: held until reset.
REQ-014 SHALL hold MemErr = 1 exactly while in state ERR; ERR forces freeze permanently.
REQ-015 SHALL increment StallCnt on every clock edge where StallF = 1, saturating at 0xFFFF.
REQ-016 SHALL increment FlushCnt on every clock edge where FlushD = 1, saturating at 0xFFFF.
REQ-017 SHALL treat register x0 as never hazarding, for both forwarding and lwStall.
REQ-018 SHALL handle a single-cycle stall (MemReqM with MemReadyM both high) without leaving RUN.

Reset
REQ-019 While reset = 0 the block SHALL hold:
- state = RUN, WaitCnt = 0, MemErr = 0, StallCnt = 0, FlushCnt = 0.
- all Stall and Flush outputs = 0, ForwardAE = ForwardBE = 00.
REQ-020 Reset asserted mid-MEMWAIT or in ERR SHALL return the block to RUN immediately and asynchronously; normal operation resumes from the first rising clk edge after reset deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10; with RegWriteM = 0 -> ForwardAE = 01; with Rs1E = 0 -> ForwardAE = 00.
- Load-use: ResultSrcE0 = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1, FlushD = 0, StallCnt +1 after the edge.
- Branch plus load-use: PCSrcE = 1 in the same case -> FlushD = FlushE = 1, StallF = 0, FlushCnt +1.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles then 1 -> StallF/D/E/M = 1 for 3 cycles, FSM returns to RUN, MemErr = 0, StallCnt = 3.
- Timeout: MemReadyM held 0 for TIMEOUT = 16 cycles -> MemErr = 1 with all stalls high; a reset pulse clears MemErr, the counters and the FSM.
- Saturation: StallCnt preloaded via 65 535 stall cycles, then 2 more -> StallCnt stays at 0xFFFF.
